// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: assembles 10-bit command words from MOSI and returns RAM read data on MISO.
// Optional concurrent assertions and covers are compiled when SPI_SLAVE_SVA_EN is defined.
module spi_slave_ctrl #(
   parameter int WORD_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
);

   localparam int CNT_W = 4;
   localparam int TXC_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [WORD_W-2:0] rx_sr_q;
   logic [WORD_W-1:0] rx_data_q;
   logic              rx_valid_q;
   logic              addr_seen_q;
   logic [DATA_W-1:0] tx_sr_q;
   logic [TXC_W-1:0]  tx_cnt_q;
   logic              tx_active_q;
   logic              tx_done_q;
   logic              miso_q;

   logic [WORD_W-1:0] word_d;
   logic              word_last;

   assign word_d    = {rx_sr_q, MOSI};
   assign word_last = (bit_cnt_q == CNT_W'(WORD_W - 1));

   assign MISO     = miso_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_sr_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         addr_seen_q <= 1'b0;
         tx_sr_q     <= '0;
         tx_cnt_q    <= '0;
         tx_active_q <= 1'b0;
         tx_done_q   <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (SS_n) begin
            // Frame end or abort: drop any partial word or pending transmission.
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            tx_cnt_q    <= '0;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
            miso_q      <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q   <= CHK_CMD;
                  bit_cnt_q <= '0;
               end
               CHK_CMD: begin
                  rx_sr_q   <= {{(WORD_W-2){1'b0}}, MOSI};
                  bit_cnt_q <= CNT_W'(1);
                  if (!MOSI)
                     state_q <= WRITE;
                  else if (addr_seen_q)
                     state_q <= READ_DATA;
                  else
                     state_q <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (bit_cnt_q < CNT_W'(WORD_W)) begin
                     rx_sr_q   <= word_d[WORD_W-2:0];
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (word_last) begin
                        rx_data_q  <= word_d;
                        rx_valid_q <= 1'b1;
                        if (word_d[WORD_W-1 -: 2] == 2'b10)
                           addr_seen_q <= 1'b1;
                        else if (word_d[WORD_W-1 -: 2] == 2'b11)
                           addr_seen_q <= 1'b0;
                     end
                  end else if (state_q == READ_DATA) begin
                     if (tx_active_q) begin
                        if (tx_cnt_q != '0) begin
                           miso_q   <= tx_sr_q[DATA_W-1];
                           tx_sr_q  <= {tx_sr_q[DATA_W-2:0], 1'b0};
                           tx_cnt_q <= tx_cnt_q - 1'b1;
                        end else begin
                           miso_q      <= 1'b0;
                           tx_active_q <= 1'b0;
                           tx_done_q   <= 1'b1;
                        end
                     end else if (!tx_done_q && !rx_valid_q && tx_valid) begin
                        // tx_valid is a held level, so the strobe cycle is skipped to avoid stale data.
                        miso_q      <= tx_data[DATA_W-1];
                        tx_sr_q     <= {tx_data[DATA_W-2:0], 1'b0};
                        tx_cnt_q    <= TXC_W'(DATA_W - 1);
                        tx_active_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef SPI_SLAVE_SVA_EN
   logic [3:0] ss_run_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ss_run_q <= '0;
      else if (SS_n)
         ss_run_q <= '0;
      else if (ss_run_q != 4'hF)
         ss_run_q <= ss_run_q + 1'b1;
   end

   a_rx_pulse: assert property (@(posedge clk) disable iff (!rst_n) rx_valid_q |=> !rx_valid_q);
   a_rx_frame: assert property (@(posedge clk) disable iff (!rst_n) rx_valid_q |-> (ss_run_q >= 4'd10));
   a_idle_miso: assert property (@(posedge clk) disable iff (!rst_n) (state_q == IDLE) |-> !miso_q);
   a_legal_state: assert property (@(posedge clk) disable iff (!rst_n)
      state_q inside {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA});
   a_ss_idle: assert property (@(posedge clk) disable iff (!rst_n) SS_n |=> (state_q == IDLE));

   c_rx_pulse: cover property (@(posedge clk) disable iff (!rst_n) rx_valid_q ##1 !rx_valid_q);
   c_rx_frame: cover property (@(posedge clk) disable iff (!rst_n) rx_valid_q && (ss_run_q >= 4'd10));
   c_idle_miso: cover property (@(posedge clk) disable iff (!rst_n) (state_q == IDLE) && !miso_q);
   c_read_data: cover property (@(posedge clk) disable iff (!rst_n) state_q == READ_DATA);
   c_ss_idle: cover property (@(posedge clk) disable iff (!rst_n) SS_n ##1 (state_q == IDLE));
`endif

endmodule
